// File: rtl/wb_nn_pkg.sv
// Shared types for the NN Wishbone initiator: FSM state names, the queued
// command record and the all-lanes byte select.
package wb_nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_nn_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_nn_cmd_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_nn_initiator_if.sv
// Wishbone classic bus between the NN initiator (master) and the NN slave.
interface wb_nn_initiator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_nn_cmd_fifo.sv
// Synchronous command FIFO; head shows the oldest entry combinationally so the
// consumer can load it on the same edge it pops.
module wb_nn_cmd_fifo
  import wb_nn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  wb_nn_cmd_t wr_cmd,
  output wb_nn_cmd_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_nn_cmd_t  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Pointers carry one wrap bit: equal pointers mean empty, equal index with
  // differing wrap bits means full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_cmd;
  end

endmodule

// File: rtl/wb_nn_initiator.sv
// Queues read/write commands and issues each as one Wishbone classic cycle to
// the NN slave, with a bus timeout, a held response and transaction counters.
module wb_nn_initiator
  import wb_nn_pkg::*;
#(
  parameter logic [31:0] IO_ADDRESS     = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CMD_DEPTH      = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic                      cmd_use_base,
  input  logic [31:0]               cmd_adr,
  input  logic [31:0]               cmd_dat,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_dat,
  output logic                      rsp_err,
  wb_nn_initiator_if.master         wbm,
  output logic [15:0]               txn_count,
  output logic [7:0]                err_count,
  output logic [1:0]                state_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUS  = BUS;
  localparam logic [1:0] S_RESP = RESP;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      txn_q, txn_d;
  logic [7:0]       err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  wb_nn_cmd_t fifo_wr;
  wb_nn_cmd_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held valid keeps its payload.
  assign cmd_ready = !fifo_full && !wb_rst_i;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_wr   = '{we: cmd_we, adr: (cmd_use_base ? IO_ADDRESS : cmd_adr), dat: cmd_dat};

  wb_nn_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_cmd (fifo_wr),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_d       = txn_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop = 1'b1;
          we_d     = fifo_head.we;
          adr_d    = fifo_head.adr;
          dat_d    = fifo_head.dat;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          tmo_d    = '0;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        // An ack on the final timeout cycle still completes the transfer.
        if (wbm.wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm.wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + 16'd1;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      txn_q       <= 16'h0;
      err_q       <= 8'h0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = stb_q ? WB_SEL_ALL : 4'h0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dat       = rsp_dat_q;
  assign rsp_err       = rsp_err_q;
  assign txn_count     = txn_q;
  assign err_count     = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_wb_nn_initiator.sv
// Bench for wb_nn_initiator: a scripted Wishbone slave with configurable wait
// states, and a transaction-level reference model for responses and counters.
module tb_wb_nn_initiator;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          TMO   = 16;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_use_base = 1'b0;
  logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  wb_nn_initiator_if bus();

  wb_nn_initiator #(.IO_ADDRESS(BASE), .TIMEOUT_CYCLES(TMO), .CMD_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_use_base(cmd_use_base), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm(bus), .txn_count(txn_count), .err_count(err_count), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // slave / monitor state
  int          slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  bit          slv_stray = 1'b0;
  int          cur_cnt = 0, last_len = 0, n_bus = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;
  bit          hold_bad = 1'b0;
  logic [31:0] obs_adr_q[$];
  logic [31:0] exp_q[$];

  // reference model results
  logic [31:0] e_adr, e_rdat;
  logic        e_err;
  int          e_len;
  logic [15:0] exp_txn = 16'h0;
  logic [7:0]  exp_err = 8'h0;
  logic [31:0] o_rdat;
  logic        o_err;
  logic [15:0] o_txn;
  logic [7:0]  o_errc;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o) begin
      if (cur_cnt == 0) begin
        cap_adr = bus.wbm_adr_o; cap_dat = bus.wbm_dat_o;
        cap_we = bus.wbm_we_o; cap_sel = bus.wbm_sel_o;
        n_bus++;
        obs_adr_q.push_back(bus.wbm_adr_o);
      end else if (bus.wbm_adr_o !== cap_adr || bus.wbm_dat_o !== cap_dat ||
                   bus.wbm_we_o !== cap_we || bus.wbm_sel_o !== cap_sel) begin
        hold_bad = 1'b1;
      end
      if (bus.wbm_stb_o !== 1'b1 || bus.wbm_sel_o !== 4'hF) hold_bad = 1'b1;
      cur_cnt++;
      bus.wbm_ack_i = (cur_cnt - 1 == slv_wait);
      bus.wbm_dat_i = bus.wbm_ack_i ? slv_rdata : $urandom;
    end else begin
      if (cur_cnt != 0) last_len = cur_cnt;
      cur_cnt = 0;
      bus.wbm_ack_i = slv_stray;
      bus.wbm_dat_i = $urandom;
      if (bus.wbm_stb_o !== 1'b0 || bus.wbm_sel_o !== 4'h0) hold_bad = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic ub, input logic [31:0] adr,
                          input logic [31:0] dat, output bit ok);
    cmd_valid = 1'b1; cmd_we = we; cmd_use_base = ub; cmd_adr = adr; cmd_dat = dat;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic do_txn(input logic we, input logic ub, input logic [31:0] adr,
                        input logic [31:0] dat, input int wt, input logic [31:0] rdata,
                        output bit ok);
    slv_wait = wt; slv_rdata = rdata; hold_bad = 1'b0;
    send_cmd(we, ub, adr, dat, ok);
    if (ok) wait_rsp(100, ok);
    o_rdat = rsp_dat; o_err = rsp_err; o_txn = txn_count; o_errc = err_count;
    consume();
  endtask

  // Transaction-level expectation: a slave that acks after wt wait states
  // succeeds if it answers within TMO cycles, otherwise the cycle aborts.
  task automatic model_txn(input logic we, input logic ub, input logic [31:0] adr,
                           input logic [31:0] rdata, input int wt);
    e_adr = ub ? BASE : adr;
    if (wt < TMO) begin
      e_err = 1'b0; e_rdat = we ? 32'h0 : rdata; e_len = wt + 1;
      exp_txn = exp_txn + 16'd1;
    end else begin
      e_err = 1'b1; e_rdat = 32'h0; e_len = TMO;
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_adr = 32'h1234;
    repeat (3) tick();
    n_cmp++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o} !== 7'h0) begin n_bad++; $display("FAIL rst_ctl got=%0h exp=0", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}); end
    n_cmp++; if ({bus.wbm_adr_o, bus.wbm_dat_o} !== 64'h0) begin n_bad++; $display("FAIL rst_adr_dat got=%0h exp=0", {bus.wbm_adr_o, bus.wbm_dat_o}); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_dat} !== 34'h0) begin n_bad++; $display("FAIL rst_rsp got=%0h exp=0", {rsp_valid, rsp_err, rsp_dat}); end
    n_cmp++; if ({txn_count, err_count} !== 24'h0) begin n_bad++; $display("FAIL rst_counters got=%0h exp=0", {txn_count, err_count}); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
    cmd_valid = 1'b0; rst = 1'b0;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got=%0b exp=1", cmd_ready); end
    repeat (4) tick();
    n_cmp++; if (n_bus !== 0) begin n_bad++; $display("FAIL rst_no_cmd got=%0d exp=0", n_bus); end
  endtask

  task automatic test_write_base();
    bit ok;
    logic [31:0] junk = $urandom;
    model_txn(1'b1, 1'b1, junk, 32'h0, 0);
    do_txn(1'b1, 1'b1, junk, 32'h0000_00A5, 0, $urandom, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_done got=0 exp=1"); end
    n_cmp++; if ({cap_we, cap_adr, cap_dat, cap_sel} !== {1'b1, BASE, 32'hA5, 4'hF}) begin n_bad++; $display("FAIL wr_bus got=%0h exp=%0h", {cap_we, cap_adr, cap_dat, cap_sel}, {1'b1, BASE, 32'hA5, 4'hF}); end
    n_cmp++; if (last_len !== 1) begin n_bad++; $display("FAIL wr_len got=%0d exp=1", last_len); end
    n_cmp++; if ({o_err, o_rdat} !== 33'h0) begin n_bad++; $display("FAIL wr_rsp got=%0h exp=0", {o_err, o_rdat}); end
    n_cmp++; if (o_txn !== 16'd1) begin n_bad++; $display("FAIL wr_txn got=%0d exp=1", o_txn); end
    n_cmp++; if (hold_bad !== 1'b0) begin n_bad++; $display("FAIL wr_hold got=1 exp=0"); end
  endtask

  task automatic test_read_wait();
    bit ok;
    model_txn(1'b0, 1'b1, 32'h0, 32'h7, 3);
    do_txn(1'b0, 1'b1, 32'h0, 32'h0, 3, 32'h0000_0007, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rd_done got=0 exp=1"); end
    n_cmp++; if ({o_err, o_rdat} !== {1'b0, 32'h7}) begin n_bad++; $display("FAIL rd_rsp got=%0h exp=7", {o_err, o_rdat}); end
    n_cmp++; if (last_len !== 4) begin n_bad++; $display("FAIL rd_len got=%0d exp=4", last_len); end
    n_cmp++; if ({cap_we, cap_adr} !== {1'b0, BASE}) begin n_bad++; $display("FAIL rd_bus got=%0h exp=%0h", {cap_we, cap_adr}, {1'b0, BASE}); end
  endtask

  task automatic test_timeout();
    bit ok;
    model_txn(1'b0, 1'b0, 32'h3000_0008, 32'h0, NEVER);
    do_txn(1'b0, 1'b0, 32'h3000_0008, 32'h0, NEVER, 32'hDEAD_BEEF, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done got=0 exp=1"); end
    n_cmp++; if (last_len !== TMO) begin n_bad++; $display("FAIL tmo_len got=%0d exp=%0d", last_len, TMO); end
    n_cmp++; if ({o_err, o_rdat} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL tmo_rsp got=%0h exp=100000000", {o_err, o_rdat}); end
    n_cmp++; if ({o_txn, o_errc} !== {exp_txn, exp_err}) begin n_bad++; $display("FAIL tmo_counters got=%0h exp=%0h", {o_txn, o_errc}, {exp_txn, exp_err}); end
    n_cmp++; if (cap_adr !== 32'h3000_0008) begin n_bad++; $display("FAIL tmo_adr got=%0h exp=30000008", cap_adr); end
  endtask

  task automatic test_ack_at_timeout();
    bit ok;
    logic [31:0] rd = $urandom;
    model_txn(1'b0, 1'b1, 32'h0, rd, TMO - 1);
    do_txn(1'b0, 1'b1, 32'h0, 32'h0, TMO - 1, rd, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL edge_done got=0 exp=1"); end
    n_cmp++; if ({o_err, o_rdat} !== {1'b0, rd}) begin n_bad++; $display("FAIL edge_rsp got=%0h exp=%0h", {o_err, o_rdat}, {1'b0, rd}); end
    n_cmp++; if (last_len !== TMO) begin n_bad++; $display("FAIL edge_len got=%0d exp=%0d", last_len, TMO); end
    n_cmp++; if ({o_txn, o_errc} !== {exp_txn, exp_err}) begin n_bad++; $display("FAIL edge_counters got=%0h exp=%0h", {o_txn, o_errc}, {exp_txn, exp_err}); end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 24; i++) begin
      logic        we = 1'($urandom_range(0, 1));
      logic        ub = 1'($urandom_range(0, 1));
      logic [31:0] adr = $urandom, dat = $urandom, rd = $urandom;
      int          wt = $urandom_range(0, 20);
      model_txn(we, ub, adr, rd, wt);
      do_txn(we, ub, adr, dat, wt, rd, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_done[%0d] got=0 exp=1", i); end
      n_cmp++; if ({cap_we, cap_adr, cap_dat} !== {we, e_adr, dat}) begin n_bad++; $display("FAIL rnd_bus[%0d] got=%0h exp=%0h", i, {cap_we, cap_adr, cap_dat}, {we, e_adr, dat}); end
      n_cmp++; if ({o_err, o_rdat} !== {e_err, e_rdat}) begin n_bad++; $display("FAIL rnd_rsp[%0d] got=%0h exp=%0h", i, {o_err, o_rdat}, {e_err, e_rdat}); end
      n_cmp++; if (last_len !== e_len) begin n_bad++; $display("FAIL rnd_len[%0d] got=%0d exp=%0d", i, last_len, e_len); end
      n_cmp++; if ({o_txn, o_errc} !== {exp_txn, exp_err}) begin n_bad++; $display("FAIL rnd_counters[%0d] got=%0h exp=%0h", i, {o_txn, o_errc}, {exp_txn, exp_err}); end
      n_cmp++; if (hold_bad !== 1'b0) begin n_bad++; $display("FAIL rnd_hold[%0d] got=1 exp=0", i); end
    end
  endtask

  task automatic test_stray_ack();
    bit ok, saw_cyc;
    logic [31:0] adr = $urandom, rd = $urandom;
    slv_wait = 2; slv_rdata = rd;
    model_txn(1'b0, 1'b0, adr, rd, 2);
    send_cmd(1'b0, 1'b0, adr, 32'h0, ok);
    if (ok) wait_rsp(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stray_done got=0 exp=1"); end
    slv_stray = 1'b1;
    repeat (4) tick();
    n_cmp++; if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, e_rdat}) begin n_bad++; $display("FAIL stray_resp_hold got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_dat}, {1'b1, 1'b0, e_rdat}); end
    n_cmp++; if (txn_count !== exp_txn) begin n_bad++; $display("FAIL stray_resp_txn got=%0d exp=%0d", txn_count, exp_txn); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    saw_cyc = 1'b0;
    repeat (4) begin tick(); if (bus.wbm_cyc_o) saw_cyc = 1'b1; end
    n_cmp++; if ({saw_cyc, rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL stray_idle got=%0b exp=00", {saw_cyc, rsp_valid}); end
    n_cmp++; if ({txn_count, err_count} !== {exp_txn, exp_err}) begin n_bad++; $display("FAIL stray_counters got=%0h exp=%0h", {txn_count, err_count}, {exp_txn, exp_err}); end
    slv_stray = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok, ready_seen, acc5;
    int nb0;
    logic [31:0] a;
    slv_wait = 1; rsp_ready = 1'b0;
    send_cmd(1'b1, 1'b0, $urandom, $urandom, ok);
    if (ok) wait_rsp(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_first got=0 exp=1"); end
    nb0 = n_bus;
    obs_adr_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      cmd_valid = 1'b1; cmd_we = 1'($urandom_range(0, 1)); cmd_use_base = 1'b0;
      cmd_adr = a; cmd_dat = $urandom;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d] got=%0b exp=1", i, cmd_ready); end
      exp_q.push_back(a);
      tick();
    end
    a = $urandom; cmd_adr = a; cmd_we = 1'b0;
    ready_seen = 1'b0;
    repeat (3) begin if (cmd_ready) ready_seen = 1'b1; tick(); end
    n_cmp++; if (ready_seen !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready got=1 exp=0"); end
    n_cmp++; if ({n_bus == nb0, rsp_valid} !== 2'b11) begin n_bad++; $display("FAIL b2b_stall got=%0d exp=%0d", n_bus, nb0); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    acc5 = 1'b0;
    for (int i = 0; i < 20 && !acc5; i++) begin
      if (cmd_ready) acc5 = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++; if (!acc5) begin n_bad++; $display("FAIL b2b_fifth got=0 exp=1"); end
    exp_q.push_back(a);
    for (int k = 0; k < 5; k++) begin
      wait_rsp(100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_rsp[%0d] got=0 exp=1", k); end
      consume();
    end
    n_cmp++; if (obs_adr_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_adr_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_adr_q.size(); k++) begin
      n_cmp++; if (obs_adr_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", k, obs_adr_q[k], exp_q[k]); end
    end
    exp_txn = exp_txn + 16'd6;
  endtask

  task automatic test_reset_mid_bus();
    bit ok, saw_cyc, saw_rsp;
    logic [31:0] a = $urandom;
    slv_wait = NEVER;
    send_cmd(1'b0, 1'b1, 32'h0, 32'h11, ok);
    send_cmd(1'b1, 1'b0, 32'h40, 32'h22, ok);
    for (int i = 0; i < 20 && !bus.wbm_cyc_o; i++) tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.wbm_cyc_o, bus.wbm_stb_o, cmd_ready, rsp_valid} !== 4'b0) begin n_bad++; $display("FAIL mid_rst_ctl got=%0b exp=0", {bus.wbm_cyc_o, bus.wbm_stb_o, cmd_ready, rsp_valid}); end
    n_cmp++; if ({txn_count, err_count} !== 24'h0) begin n_bad++; $display("FAIL mid_rst_counters got=%0h exp=0", {txn_count, err_count}); end
    @(posedge clk); #1 rst = 1'b0;
    exp_txn = 16'h0; exp_err = 8'h0;
    saw_cyc = 1'b0; saw_rsp = 1'b0;
    repeat (20) begin tick(); if (bus.wbm_cyc_o) saw_cyc = 1'b1; if (rsp_valid) saw_rsp = 1'b1; end
    n_cmp++; if ({saw_cyc, saw_rsp} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_quiet got=%0b exp=00", {saw_cyc, saw_rsp}); end
    obs_adr_q.delete();
    model_txn(1'b1, 1'b0, a, 32'h0, 0);
    do_txn(1'b1, 1'b0, a, $urandom, 0, $urandom, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_rst_after got=0 exp=1"); end
    n_cmp++; if (obs_adr_q.size() !== 1 || obs_adr_q[0] !== a) begin n_bad++; $display("FAIL mid_rst_fifo got=%0d exp=1", obs_adr_q.size()); end
    n_cmp++; if (o_txn !== exp_txn) begin n_bad++; $display("FAIL mid_rst_txn got=%0d exp=%0d", o_txn, exp_txn); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_base();
    test_read_wait();
    test_timeout();
    test_ack_at_timeout();
    test_random();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
